enabled_register: RTL and testbench



---
 rtl/enabled_register.sv | 83 ++++++++
 tb/tb_enabled_register.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/enabled_register.sv
// enabled_register: single-stage, clock-enabled, synchronously resettable
// storage register. It is the basic state element for datapath and control
// flops in pipeline blocks such as the skid buffer.
//
// Optional build macro: REGISTER_FORMAL_EN compiles in formal properties
// (assertions plus one cover). The default build contains only the
// register itself. Ports and behaviour are the same in both builds.
module enabled_register #(
  parameter int unsigned             WORD_WIDTH  = 8,
  parameter logic [WORD_WIDTH-1:0]   RESET_VALUE = {WORD_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic [WORD_WIDTH-1:0] i_data,
  output logic [WORD_WIDTH-1:0] o_data
);

  // Storage flop. The declaration initialiser gives it a defined power-up
  // value before the first reset; parents such as the skid buffer ready
  // flop depend on starting at RESET_VALUE.
  logic [WORD_WIDTH-1:0] data_p1 = RESET_VALUE;

  // Capture stage: reset wins over enable, otherwise load on enable, else
  // hold. With clk_en low, i_data is never sampled, so X values on i_data
  // cannot reach the flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_p1 <= RESET_VALUE;
    end else if (clk_en) begin
      data_p1 <= i_data;
    end
  end

  // The output is the flop itself; there is no combinational path from
  // any input to o_data.
  assign o_data = data_p1;

`ifdef REGISTER_FORMAL_EN
  // Becomes 1 after the first edge, so that $past values are meaningful.
  logic past_valid = 1'b0;

  // Track whether at least one clock edge has occurred.
  always_ff @(posedge clk) begin
    past_valid <= 1'b1;
  end

  // Before any edge, the register must already hold RESET_VALUE.
  always_comb begin
    if (!past_valid) begin
      assert (o_data == RESET_VALUE);
    end
  end

  // Reset in the previous cycle forces RESET_VALUE.
  property p_reset_load;
    @(posedge clk) past_valid && $past(reset) |-> (o_data == RESET_VALUE);
  endproperty
  a_reset_load: assert property (p_reset_load);

  // Enable without reset captures the previous i_data.
  property p_enable_load;
    @(posedge clk) past_valid && !$past(reset) && $past(clk_en)
      |-> (o_data == $past(i_data));
  endproperty
  a_enable_load: assert property (p_enable_load);

  // No reset and no enable leaves the value untouched.
  property p_hold;
    @(posedge clk) past_valid && !$past(reset) && !$past(clk_en)
      |-> $stable(o_data);
  endproperty
  a_hold: assert property (p_hold);

  // Reach a capture of a nonzero word that is then held for a cycle.
  property p_capture_then_hold;
    @(posedge clk) past_valid && !reset && clk_en && (i_data != '0)
      ##1 !reset && !clk_en ##1 (o_data != '0);
  endproperty
  c_capture_then_hold: cover property (p_capture_then_hold);
`endif

endmodule

// File: tb/tb_enabled_register.sv
// tb_enabled_register: directed-vector bench for enabled_register.
// Two instances: an 8-bit register with reset value 8'h5A and a 1-bit
// register with reset value 1'b1.
module tb_enabled_register;

  logic       clk = 1'b0;

  // 8-bit instance controls
  logic       reset  = 1'b0;
  logic       clk_en = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic [7:0] o_data;

  // 1-bit instance controls
  logic       reset1  = 1'b0;
  logic       clk_en1 = 1'b0;
  logic       i_data1 = 1'b0;
  logic       o_data1;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  enabled_register #(
    .WORD_WIDTH (8),
    .RESET_VALUE(8'h5A)
  ) dut8 (
    .clk   (clk),
    .reset (reset),
    .clk_en(clk_en),
    .i_data(i_data),
    .o_data(o_data)
  );

  enabled_register #(
    .WORD_WIDTH (1),
    .RESET_VALUE(1'b1)
  ) dut1 (
    .clk   (clk),
    .reset (reset1),
    .clk_en(clk_en1),
    .i_data(i_data1),
    .o_data(o_data1)
  );

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_power_up();
    #1;
    vectors++;
    if (o_data !== 8'h5A) begin
      miscompares++;
      $display("FAIL power_up_w8: got %h expected %h", o_data, 8'h5A);
    end
    vectors++;
    if (o_data1 !== 1'b1) begin
      miscompares++;
      $display("FAIL power_up_w1: got %b expected %b", o_data1, 1'b1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; clk_en = 1'b1; i_data = 8'hFF;
    step();
    vectors++;
    if (o_data !== 8'h5A) begin
      miscompares++;
      $display("FAIL reset: got %h expected %h", o_data, 8'h5A);
    end
  endtask

  task automatic test_load();
    logic [7:0] vec [3] = '{8'h01, 8'h02, 8'h03};
    reset = 1'b0; clk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_data = vec[i];
      step();
      vectors++;
      if (o_data !== vec[i]) begin
        miscompares++;
        $display("FAIL load[%0d]: got %h expected %h", i, o_data, vec[i]);
      end
    end
  endtask

  task automatic test_hold();
    reset = 1'b0; clk_en = 1'b1; i_data = 8'hA5;
    step();
    vectors++;
    if (o_data !== 8'hA5) begin
      miscompares++;
      $display("FAIL hold_load: got %h expected %h", o_data, 8'hA5);
    end
    clk_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      i_data = (i == 5) ? 8'hxx : 8'($urandom);
      step();
      vectors++;
      if (o_data !== 8'hA5) begin
        miscompares++;
        $display("FAIL hold[%0d]: got %h expected %h", i, o_data, 8'hA5);
      end
    end
  endtask

  task automatic test_priority();
    reset = 1'b0; clk_en = 1'b1; i_data = 8'h33;
    step();
    vectors++;
    if (o_data !== 8'h33) begin
      miscompares++;
      $display("FAIL priority_load: got %h expected %h", o_data, 8'h33);
    end
    reset = 1'b1; clk_en = 1'b1; i_data = 8'hCC;
    step();
    vectors++;
    if (o_data !== 8'h5A) begin
      miscompares++;
      $display("FAIL priority: got %h expected %h", o_data, 8'h5A);
    end
  endtask

  task automatic test_reset_release();
    // Reset is still high from the previous test; release with enable.
    reset = 1'b0; clk_en = 1'b1; i_data = 8'h77;
    step();
    vectors++;
    if (o_data !== 8'h77) begin
      miscompares++;
      $display("FAIL reset_release: got %h expected %h", o_data, 8'h77);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vec [4] = '{8'h00, 8'hFF, 8'h80, 8'h01};
    reset = 1'b0; clk_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_data = vec[i];
      step();
      vectors++;
      if (o_data !== vec[i]) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", i, o_data, vec[i]);
      end
    end
    // Reset without enable still loads RESET_VALUE.
    reset = 1'b1; clk_en = 1'b0; i_data = 8'h11;
    step();
    vectors++;
    if (o_data !== 8'h5A) begin
      miscompares++;
      $display("FAIL reset_no_en: got %h expected %h", o_data, 8'h5A);
    end
    reset = 1'b0;
  endtask

  task automatic test_width1();
    logic       d   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       en  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       rst [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       exp [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      reset1 = rst[i]; clk_en1 = en[i]; i_data1 = d[i];
      step();
      vectors++;
      if (o_data1 !== exp[i]) begin
        miscompares++;
        $display("FAIL width1[%0d]: got %b expected %b", i, o_data1, exp[i]);
      end
    end
    reset1 = 1'b0; clk_en1 = 1'b0;
  endtask

  initial begin
    test_power_up();
    test_reset();
    test_load();
    test_hold();
    test_priority();
    test_reset_release();
    test_back_to_back();
    test_width1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
